morse_letter_queue: RTL and testbench

Letter queue and display sequencer for the Morse decoder path. It accepts decoded ASCII letters from the Morse decoder as one-cycle valid pulses and buffers them in a small FIFO. It shows them one at a time on the 8-LED Pmod, advancing on a button press or on an auto-scroll timer. It replaces the direct "latch letter on done" path between the decoder and the LED register, so letters keyed faster than the operator reads them are not lost.

---
 rtl/morse_letter_queue.sv | 144 ++++++++++++++
 tb/tb_morse_letter_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_letter_queue.sv
// Letter queue and display sequencer: buffers decoded Morse letters in a FIFO
// and shows them one at a time, advancing on a button edge or an auto-scroll timer.
module morse_letter_queue #(
  parameter int DEPTH_LOG2  = 3,
  parameter int SCROLL_BITS = 27
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            letter,
  input  logic                  letter_valid,
  input  logic                  advance,
  input  logic                  auto_scroll,
  input  logic                  clear,
  output logic [7:0]            display,
  output logic                  display_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL  = DEPTH[DEPTH_LOG2:0];
  localparam logic [SCROLL_BITS-1:0] TMR_ONE  = 1;

  typedef enum logic {S_EMPTY, S_SHOW} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [7:0]              r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_count;
  logic [7:0]              r_display;
  logic                    r_display_valid;
  logic                    r_overflow;
  logic [SCROLL_BITS-1:0]  r_timer;
  logic                    r_adv_q;

  logic w_adv_rise;
  logic w_timer_max;
  logic w_tick;
  logic w_pop;
  logic w_blank;
  logic w_push;
  logic w_drop;
  logic w_full;

  assign w_adv_rise  = advance & ~r_adv_q;
  assign w_timer_max = (r_timer == {SCROLL_BITS{1'b1}});
  assign w_tick      = (r_state == S_SHOW) & (w_adv_rise | (auto_scroll & w_timer_max));
  assign w_full      = (r_count == CNT_FULL);
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign w_push      = letter_valid & ~clear & (~w_full | w_pop);
  assign w_drop      = letter_valid & ~clear & w_full & ~w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_blank      = 1'b0;
    if (clear) begin
      w_state_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (r_count != '0) begin
            w_pop        = 1'b1;
            w_state_next = S_SHOW;
          end
        end
        S_SHOW: begin
          if (w_tick) begin
            if (r_count != '0) begin
              w_pop = 1'b1;
            end else begin
              w_blank      = 1'b1;
              w_state_next = S_EMPTY;
            end
          end
        end
        default: w_state_next = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= letter;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_display       <= 8'h00;
      r_display_valid <= 1'b0;
      r_overflow      <= 1'b0;
      r_timer         <= '0;
      r_adv_q         <= 1'b1;
    end else begin
      r_adv_q <= advance;
      if (clear) begin
        r_wr_ptr        <= '0;
        r_rd_ptr        <= '0;
        r_count         <= '0;
        r_display       <= 8'h00;
        r_display_valid <= 1'b0;
        r_overflow      <= 1'b0;
        r_timer         <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop) begin
          r_rd_ptr        <= r_rd_ptr + PTR_ONE;
          r_display       <= r_mem[r_rd_ptr];
          r_display_valid <= 1'b1;
        end else if (w_blank) begin
          r_display       <= 8'h00;
          r_display_valid <= 1'b0;
        end
        if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
        else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
        if (w_drop) r_overflow <= 1'b1;
        // Expiry always produces a tick, so the timer never wraps on its own.
        if (w_pop || w_tick || !auto_scroll || r_state != S_SHOW) r_timer <= '0;
        else                                                      r_timer <= r_timer + TMR_ONE;
      end
    end
  end

  assign display       = r_display;
  assign display_valid = r_display_valid;
  assign count         = r_count;
  assign empty         = (r_count == '0);
  assign full          = w_full;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_morse_letter_queue.sv
// Directed bench for morse_letter_queue with a short auto-scroll period.
module tb_morse_letter_queue;

  logic       clk;
  logic       reset;
  logic [7:0] letter;
  logic       letter_valid;
  logic       advance;
  logic       auto_scroll;
  logic       clear;
  logic [7:0] display;
  logic       display_valid;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  morse_letter_queue #(.DEPTH_LOG2(3), .SCROLL_BITS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .letter       (letter),
    .letter_valid (letter_valid),
    .advance      (advance),
    .auto_scroll  (auto_scroll),
    .clear        (clear),
    .display      (display),
    .display_valid(display_valid),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic adv_pulse();
    advance = 1'b1;
    cyc();
    advance = 1'b0;
    cyc();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  logic [7:0] exp_seq [6];

  initial begin
    reset = 1'b1; letter = 8'h00; letter_valid = 1'b0; advance = 1'b0;
    auto_scroll = 1'b0; clear = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_display", {24'h0, display}, 32'h00);
    chk("rst_valid", {31'h0, display_valid}, 32'h0);
    chk("rst_count", {28'h0, count}, 32'h0);
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_full", {31'h0, full}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);

    // Single letter from EMPTY: two-edge display latency.
    letter = 8'h53; letter_valid = 1'b1;
    cyc();
    letter_valid = 1'b0;
    chk("push_count", {28'h0, count}, 32'h1);
    chk("push_empty", {31'h0, empty}, 32'h0);
    chk("push_notyet", {31'h0, display_valid}, 32'h0);
    cyc();
    chk("load_display", {24'h0, display}, 32'h53);
    chk("load_valid", {31'h0, display_valid}, 32'h1);
    chk("load_count", {28'h0, count}, 32'h0);

    // Auto-scroll S O S, 16 cycles each.
    do_clear();
    chk("clr_display", {24'h0, display}, 32'h00);
    auto_scroll = 1'b1;
    letter = 8'h53; letter_valid = 1'b1;
    cyc();
    letter = 8'h4F;
    cyc();
    chk("as_k0", {24'h0, display}, 32'h53);
    for (int k = 1; k <= 48; k++) begin
      letter_valid = (k == 1);
      letter = 8'h53;
      cyc();
      letter_valid = 1'b0;
      if (k == 15) chk("as_k15", {24'h0, display}, 32'h53);
      if (k == 16) chk("as_k16", {24'h0, display}, 32'h4F);
      if (k == 31) chk("as_k31", {24'h0, display}, 32'h4F);
      if (k == 32) chk("as_k32", {24'h0, display}, 32'h53);
      if (k == 47) chk("as_k47", {24'h0, display}, 32'h53);
      if (k == 48) begin
        chk("as_end_display", {24'h0, display}, 32'h00);
        chk("as_end_valid", {31'h0, display_valid}, 32'h0);
      end
    end
    auto_scroll = 1'b0;

    // Fill to full while showing, drop one, then push+pop while full.
    letter = 8'h41; letter_valid = 1'b1;
    cyc();
    letter_valid = 1'b0;
    cyc();
    chk("fill_show", {24'h0, display}, 32'h41);
    for (int j = 0; j < 9; j++) begin
      letter = 8'h61 + 8'(j); letter_valid = 1'b1;
      cyc();
    end
    letter_valid = 1'b0;
    chk("fill_count", {28'h0, count}, 32'h8);
    chk("fill_full", {31'h0, full}, 32'h1);
    chk("fill_overflow", {31'h0, overflow}, 32'h1);
    chk("fill_hold", {24'h0, display}, 32'h41);
    letter = 8'h7A; letter_valid = 1'b1; advance = 1'b1;
    cyc();
    letter_valid = 1'b0; advance = 1'b0;
    chk("pp_count", {28'h0, count}, 32'h8);
    chk("pp_full", {31'h0, full}, 32'h1);
    chk("pp_display", {24'h0, display}, 32'h61);
    chk("pp_overflow", {31'h0, overflow}, 32'h1);
    cyc();
    exp_seq = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
    for (int j = 0; j < 6; j++) begin
      adv_pulse();
      chk("order_display", {24'h0, display}, {24'h0, exp_seq[j]});
      chk("order_count", {28'h0, count}, 32'(7 - j));
    end

    // Clear beats push and advance in the same cycle.
    clear = 1'b1; letter = 8'h55; letter_valid = 1'b1; advance = 1'b1;
    cyc();
    clear = 1'b0; letter_valid = 1'b0; advance = 1'b0;
    chk("clr_count", {28'h0, count}, 32'h0);
    chk("clr_disp", {24'h0, display}, 32'h00);
    chk("clr_valid", {31'h0, display_valid}, 32'h0);
    chk("clr_overflow", {31'h0, overflow}, 32'h0);
    chk("clr_empty", {31'h0, empty}, 32'h1);
    cyc(); cyc();
    chk("clr_nostore_count", {28'h0, count}, 32'h0);
    chk("clr_nostore_valid", {31'h0, display_valid}, 32'h0);

    // Held advance counts once.
    for (int j = 0; j < 4; j++) begin
      letter = 8'h42 + 8'(j); letter_valid = 1'b1;
      cyc();
    end
    letter_valid = 1'b0;
    chk("hold_pre_display", {24'h0, display}, 32'h42);
    chk("hold_pre_count", {28'h0, count}, 32'h3);
    advance = 1'b1;
    repeat (100) cyc();
    chk("hold_display", {24'h0, display}, 32'h43);
    chk("hold_count", {28'h0, count}, 32'h2);

    // Asynchronous reset with advance held through release.
    reset = 1'b1;
    #1;
    chk("arst_display", {24'h0, display}, 32'h00);
    chk("arst_valid", {31'h0, display_valid}, 32'h0);
    chk("arst_count", {28'h0, count}, 32'h0);
    cyc(); cyc();
    reset = 1'b0;
    letter = 8'h46; letter_valid = 1'b1;
    cyc();
    letter = 8'h47;
    cyc();
    letter_valid = 1'b0;
    chk("rel_display", {24'h0, display}, 32'h46);
    chk("rel_count", {28'h0, count}, 32'h1);
    repeat (5) cyc();
    chk("rel_hold_display", {24'h0, display}, 32'h46);
    chk("rel_hold_count", {28'h0, count}, 32'h1);
    advance = 1'b0;
    cyc();
    adv_pulse();
    chk("rel_adv_display", {24'h0, display}, 32'h47);

    // Pointer wrap-around across 20 letters.
    do_clear();
    for (int i = 0; i < 20; i++) begin
      letter = 8'(65 + i); letter_valid = 1'b1;
      cyc();
      letter_valid = 1'b0;
      if (i == 0) cyc();
      else        adv_pulse();
      chk("wrap_display", {24'h0, display}, 32'(65 + i));
      chk("wrap_count", {28'h0, count}, 32'h0);
    end
    chk("wrap_overflow", {31'h0, overflow}, 32'h0);
    chk("wrap_valid", {31'h0, display_valid}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
